mem_read_arbiter: RTL and testbench

- Shares one AXI-style memory read port among N read requesters, e.g. the BUFFER_LEN stream-buffer slots behind the instruction cache.
- Accepts per-requester burst read addresses and grants them round-robin through a one-entry AR holding register.
- Tags each burst with the requester index as its ID, and routes returning data beats back by ID.
- Enforces one outstanding burst per requester and a global outstanding limit.

---
 rtl/mem_arb_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 58 +++++
 rtl/mem_read_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_read_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_arb_pkg
// Description : Shared types and constants for the memory read arbiter.
//               Holds the AXI burst-length width and default-width
//               ID / AR-request types for blocks built at the default size.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    // Width of the AXI ARLEN field (burst length minus one)
    localparam int AXI_LEN_WIDTH = 8;

    // Default sizing of the instruction-side instance
    localparam int C_DEFAULT_N          = 8;
    localparam int C_DEFAULT_ADDR_WIDTH = 26;
    localparam int C_DEFAULT_ID_WIDTH   = $clog2(C_DEFAULT_N);

    // Requester index carried on the memory port as the transaction ID
    typedef logic [C_DEFAULT_ID_WIDTH-1:0] arb_id_t;

    // One burst read address as held in the AR register
    typedef struct packed {
        logic [C_DEFAULT_ADDR_WIDTH-1:0] addr;
        logic [AXI_LEN_WIDTH-1:0]        len;
        arb_id_t                         id;
    } ar_req_t;

endpackage : mem_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : N-wide round-robin picker. Grants the first requesting index
//               at or after the internal pointer (wrapping modulo N). The
//               pointer moves to one past the winner when i_advance is set.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter  int N         = 8,
    localparam int IDX_WIDTH = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         i_req,
    input  logic                 i_advance,
    output logic [N-1:0]         o_grant,
    output logic [IDX_WIDTH-1:0] o_grant_idx,
    output logic                 o_grant_valid
);

    logic [IDX_WIDTH-1:0] r_ptr;
    logic [N-1:0]         w_grant;
    logic [IDX_WIDTH-1:0] w_idx;
    logic [IDX_WIDTH-1:0] w_cand;
    logic                 w_found;

    // Scan from the pointer forward, wrapping, and take the first request
    always_comb begin
        w_grant = '0;
        w_idx   = '0;
        w_cand  = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            w_cand = IDX_WIDTH'((int'(r_ptr) + k) % N);
            if (!w_found && i_req[w_cand]) begin
                w_found         = 1'b1;
                w_idx           = w_cand;
                w_grant[w_cand] = 1'b1;
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_idx == IDX_WIDTH'(N - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_grant       = w_grant;
    assign o_grant_idx   = w_idx;
    assign o_grant_valid = w_found;

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_read_arbiter
// Description : Shares one AXI-style read port among N requesters. Grants
//               burst addresses round-robin into a one-entry AR register,
//               tags each burst with the requester index as its ID, routes
//               returning beats by ID, and limits in-flight bursts to one per
//               requester and MAX_OUTSTANDING overall. Unowned beats are
//               accepted, dropped and flagged on the sticky err output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_read_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N               = 8,
    parameter  int ADDR_WIDTH      = 26,
    parameter  int DATA_WIDTH      = 32,
    parameter  int MAX_OUTSTANDING = 4,
    localparam int ID_WIDTH        = $clog2(N)
) (
    input  logic                       clk,
    input  logic                       rst,
    // requester side
    input  logic [N-1:0]               req_arvalid,
    input  logic [N*ADDR_WIDTH-1:0]    req_araddr,
    input  logic [N*AXI_LEN_WIDTH-1:0] req_arlen,
    output logic [N-1:0]               req_arready,
    output logic [N-1:0]               req_rvalid,
    output logic [DATA_WIDTH-1:0]      req_rdata,
    output logic                       req_rlast,
    input  logic [N-1:0]               req_rready,
    // memory side
    output logic                       mem_arvalid,
    output logic [ADDR_WIDTH-1:0]      mem_araddr,
    output logic [AXI_LEN_WIDTH-1:0]   mem_arlen,
    output logic [ID_WIDTH-1:0]        mem_arid,
    input  logic                       mem_arready,
    input  logic                       mem_rvalid,
    input  logic [DATA_WIDTH-1:0]      mem_rdata,
    input  logic                       mem_rlast,
    input  logic [ID_WIDTH-1:0]        mem_rid,
    output logic                       mem_rready,
    // status
    output logic                       err
);

    localparam int CNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    // Number of encodable IDs; may exceed N when N is not a power of two
    localparam int ID_SPACE  = 1 << ID_WIDTH;
    localparam logic [CNT_WIDTH-1:0] C_MAX_CNT = CNT_WIDTH'(MAX_OUTSTANDING);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]    addr;
        logic [AXI_LEN_WIDTH-1:0] len;
        logic [ID_WIDTH-1:0]      id;
    } ar_hold_t;

    ar_hold_t              r_ar;
    logic                  r_arvalid;
    logic [N-1:0]          r_busy;
    logic [CNT_WIDTH-1:0]  r_out_cnt;
    logic                  r_err;

    logic                  w_can_grant;
    logic [N-1:0]          w_eligible;
    logic [N-1:0]          w_arb_req;
    logic [N-1:0]          w_grant;
    logic [ID_WIDTH-1:0]   w_grant_idx;
    logic                  w_grant_valid;
    logic [ID_SPACE-1:0]   w_busy_ext;
    logic [ID_SPACE-1:0]   w_rready_ext;
    logic                  w_owner_ok;
    logic                  w_done;
    logic [N-1:0]          w_done_vec;
    logic [N-1:0]          w_rvalid;

    // ------------------------------------------------------------------
    // Address arbitration
    // ------------------------------------------------------------------
    assign w_eligible  = req_arvalid & ~r_busy;
    // New grants only into an empty AR register and below the in-flight cap
    assign w_can_grant = !r_arvalid && (r_out_cnt < C_MAX_CNT);
    assign w_arb_req   = w_can_grant ? w_eligible : '0;

    rr_arbiter #(
        .N (N)
    ) u_rr_arbiter (
        .clk           (clk),
        .rst           (rst),
        .i_req         (w_arb_req),
        .i_advance     (w_grant_valid),
        .o_grant       (w_grant),
        .o_grant_idx   (w_grant_idx),
        .o_grant_valid (w_grant_valid)
    );

    assign req_arready = w_grant;

    // AR holding register: loads on grant, empties after the memory handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            r_arvalid <= 1'b0;
            r_ar      <= '0;
        end else if (w_grant_valid) begin
            r_arvalid <= 1'b1;
            r_ar.addr <= req_araddr[w_grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
            r_ar.len  <= req_arlen[w_grant_idx*AXI_LEN_WIDTH +: AXI_LEN_WIDTH];
            r_ar.id   <= w_grant_idx;
        end else if (r_arvalid && mem_arready) begin
            r_arvalid <= 1'b0;
        end
    end

    assign mem_arvalid = r_arvalid;
    assign mem_araddr  = r_ar.addr;
    assign mem_arlen   = r_ar.len;
    assign mem_arid    = r_ar.id;

    // ------------------------------------------------------------------
    // Read data routing
    // ------------------------------------------------------------------
    // Zero-extend to the full ID space so out-of-range IDs read as not owned
    assign w_busy_ext   = ID_SPACE'(r_busy);
    assign w_rready_ext = ID_SPACE'(req_rready);
    assign w_owner_ok   = w_busy_ext[mem_rid];

    // Beats with no owner are swallowed so the memory port never stalls on them
    assign mem_rready = w_owner_ok ? w_rready_ext[mem_rid] : 1'b1;
    assign w_done     = mem_rvalid && mem_rready && mem_rlast && w_owner_ok;

    // Per-requester valid and completion strobes decoded from the beat ID
    always_comb begin
        w_rvalid   = '0;
        w_done_vec = '0;
        for (int i = 0; i < N; i++) begin
            w_rvalid[i]   = mem_rvalid && (mem_rid == ID_WIDTH'(i)) && r_busy[i];
            w_done_vec[i] = w_done && (mem_rid == ID_WIDTH'(i));
        end
    end

    assign req_rvalid = w_rvalid;
    assign req_rdata  = mem_rdata;
    assign req_rlast  = mem_rlast;

    // ------------------------------------------------------------------
    // Outstanding tracking
    // ------------------------------------------------------------------
    // Busy set on grant, cleared on last beat; a grant never targets a busy
    // index, so set and clear cannot collide
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= (r_busy | w_grant) & ~w_done_vec;
        end
    end

    // In-flight burst count; grant and completion together cancel out
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_cnt <= '0;
        end else begin
            case ({w_grant_valid, w_done})
                2'b10:   r_out_cnt <= r_out_cnt + 1'b1;
                2'b01:   r_out_cnt <= r_out_cnt - 1'b1;
                default: r_out_cnt <= r_out_cnt;
            endcase
        end
    end

    // Sticky flag for any beat whose ID has no burst in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (mem_rvalid && !w_owner_ok) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;

endmodule : mem_read_arbiter
`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_read_arbiter
// Description : Self-checking bench for mem_read_arbiter. Random requesters
//               and a random-latency in-order memory drive the DUT; a
//               set-based reference model predicts grants, and a monitor
//               process pops expected AR / beat records from queues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_read_arbiter;
    import mem_arb_pkg::*;

    localparam int N    = 8;
    localparam int AW   = 26;
    localparam int DW   = 32;
    localparam int MAXO = 4;
    localparam int IDW  = $clog2(N);

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_arvalid;
    logic [N*AW-1:0]   req_araddr;
    logic [N*8-1:0]    req_arlen;
    logic [N-1:0]      req_arready;
    logic [N-1:0]      req_rvalid;
    logic [DW-1:0]     req_rdata;
    logic              req_rlast;
    logic [N-1:0]      req_rready;
    logic              mem_arvalid;
    logic [AW-1:0]     mem_araddr;
    logic [7:0]        mem_arlen;
    logic [IDW-1:0]    mem_arid;
    logic              mem_arready;
    logic              mem_rvalid;
    logic [DW-1:0]     mem_rdata;
    logic              mem_rlast;
    logic [IDW-1:0]    mem_rid;
    logic              mem_rready;
    logic              err;

    always #5 clk = ~clk;

    mem_read_arbiter #(
        .N (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk (clk), .rst (rst),
        .req_arvalid (req_arvalid), .req_araddr (req_araddr), .req_arlen (req_arlen),
        .req_arready (req_arready), .req_rvalid (req_rvalid), .req_rdata (req_rdata),
        .req_rlast (req_rlast), .req_rready (req_rready),
        .mem_arvalid (mem_arvalid), .mem_araddr (mem_araddr), .mem_arlen (mem_arlen),
        .mem_arid (mem_arid), .mem_arready (mem_arready), .mem_rvalid (mem_rvalid),
        .mem_rdata (mem_rdata), .mem_rlast (mem_rlast), .mem_rid (mem_rid),
        .mem_rready (mem_rready), .err (err)
    );

    typedef struct { int id; logic [AW-1:0] addr; logic [7:0] len; } ar_t;
    typedef struct { int id; logic [DW-1:0] data; logic last; } beat_t;

    int tests = 0;
    int fails = 0;

    ar_t   exp_ar_q[$];
    beat_t exp_beat_q[$];
    ar_t   mem_q[$];

    // reference model of the arbitration rules
    bit   m_busy[N];
    int   m_cnt;
    int   m_last;
    bit   m_ar_full;

    // requester and memory stimulus state
    bit        rq_pend[N];
    logic [AW-1:0] rq_addr[N];
    logic [7:0]    rq_len[N];
    bit  beat_driving;
    int  beat_no;
    int  p_new, p_arready, p_rvalid, p_rready;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] mem_word(input logic [AW-1:0] a, input int b);
        return {6'h2A, a} + DW'(b) * 32'h0101_0101;
    endfunction

    function automatic bit any_pend();
        bit r = 0;
        for (int i = 0; i < N; i++) r |= rq_pend[i];
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 0;
            rq_pend[i] = 0;
        end
        m_cnt = 0; m_last = N - 1; m_ar_full = 0;
        beat_driving = 0; beat_no = 0;
        exp_ar_q.delete(); exp_beat_q.delete(); mem_q.delete();
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            if (!rq_pend[i] && $urandom_range(99) < p_new) begin
                rq_pend[i] = 1;
                rq_addr[i] = AW'($urandom) & ~AW'(3);
                rq_len[i]  = 8'($urandom_range(3));
            end
            req_arvalid[i]        = rq_pend[i];
            req_araddr[i*AW +: AW] = rq_addr[i];
            req_arlen[i*8 +: 8]    = rq_len[i];
            req_rready[i]         = ($urandom_range(99) < p_rready);
        end
        mem_arready = ($urandom_range(99) < p_arready);
        if (!beat_driving && mem_q.size() > 0 && $urandom_range(99) < p_rvalid)
            beat_driving = 1;
        mem_rvalid = beat_driving;
        if (beat_driving) begin
            mem_rid   = IDW'(mem_q[0].id);
            mem_rdata = mem_word(mem_q[0].addr, beat_no);
            mem_rlast = (beat_no == int'(mem_q[0].len));
        end else begin
            mem_rid   = IDW'($urandom);
            mem_rdata = $urandom;
            mem_rlast = 1'b0;
        end
    endtask

    // One clock cycle: drive, check combinational outputs, advance the model
    task automatic step();
        int g;
        int j;
        logic [N-1:0] exp_grant;
        drive_inputs();
        #1;
        g = -1;
        if (!m_ar_full && m_cnt < MAXO) begin
            for (int k = 1; k <= N; k++) begin
                j = (m_last + k) % N;
                if (g < 0 && rq_pend[j] && !m_busy[j]) g = j;
            end
        end
        exp_grant = (g >= 0) ? (N'(1) << g) : '0;
        check("req_arready", req_arready, exp_grant);
        check("mem_arvalid", mem_arvalid, m_ar_full);
        if (beat_driving) begin
            check("mem_rready", mem_rready, req_rready[mem_q[0].id]);
            check("req_rvalid", req_rvalid, N'(1) << mem_q[0].id);
        end else begin
            check("req_rvalid_idle", req_rvalid, '0);
        end
        // memory accepts the address
        if (mem_arvalid && mem_arready)
            mem_q.push_back('{int'(mem_arid), mem_araddr, mem_arlen});
        if (mem_arready) m_ar_full = 0;
        // beat handshake and completion
        if (beat_driving && mem_rready) begin
            if (mem_rlast) begin
                m_busy[mem_q[0].id] = 0;
                m_cnt--;
                void'(mem_q.pop_front());
                beat_no = 0;
            end else begin
                beat_no++;
            end
            beat_driving = 0;
        end
        if (g >= 0) begin
            m_ar_full = 1; m_busy[g] = 1; m_cnt++; m_last = g;
            exp_ar_q.push_back('{g, rq_addr[g], rq_len[g]});
            for (int b = 0; b <= int'(rq_len[g]); b++)
                exp_beat_q.push_back('{g, mem_word(rq_addr[g], b), (b == int'(rq_len[g]))});
        end
        for (int i = 0; i < N; i++)
            if (req_arready[i]) rq_pend[i] = 0;
        @(negedge clk);
    endtask

    task automatic drain();
        int cyc = 0;
        p_new = 0; p_arready = 100; p_rvalid = 100; p_rready = 100;
        while ((exp_beat_q.size() > 0 || exp_ar_q.size() > 0 || any_pend()) && cyc < 500) begin
            step();
            cyc++;
        end
        tests++;
        if (cyc >= 500) begin
            fails++;
            $display("FAIL drain_timeout: %0d beats still expected after %0d cycles", exp_beat_q.size(), cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a handshake
    bit              hold_valid = 0;
    logic [63:0]     hold_val;
    initial begin
        ar_t   ea;
        beat_t eb;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                hold_valid = 0;
            end else begin
                if (hold_valid)
                    check("ar_stable", {mem_arvalid, mem_araddr, mem_arlen, mem_arid},
                          hold_val);
                hold_valid = mem_arvalid && !mem_arready;
                hold_val   = {1'b1, mem_araddr, mem_arlen, mem_arid};
                if (mem_arvalid && mem_arready) begin
                    tests++;
                    if (exp_ar_q.size() == 0) begin
                        fails++;
                        $display("FAIL ar_unexpected: handshake id %0d with no grant pending", mem_arid);
                    end else begin
                        ea = exp_ar_q.pop_front();
                        check("ar_addr", mem_araddr, ea.addr);
                        check("ar_len", mem_arlen, ea.len);
                        check("ar_id", mem_arid, ea.id);
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (req_rvalid[i] && req_rready[i]) begin
                        tests++;
                        if (exp_beat_q.size() == 0) begin
                            fails++;
                            $display("FAIL beat_unexpected: requester %0d got a beat", i);
                        end else begin
                            eb = exp_beat_q.pop_front();
                            check("beat_owner", i, eb.id);
                            check("beat_data", req_rdata, eb.data);
                            check("beat_last", req_rlast, eb.last);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_arvalid = '0; req_araddr = '0; req_arlen = '0; req_rready = '0;
        mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0; mem_rid = '0;
        for (int i = 0; i < N; i++) begin rq_addr[i] = '0; rq_len[i] = '0; end
        model_reset();
        repeat (2) @(negedge clk);
        #1;
        check("rst_mem_arvalid", mem_arvalid, 0);
        check("rst_err", err, 0);
        check("rst_busy", dut.r_busy, 0);
        check("rst_out_cnt", dut.r_out_cnt, 0);
        check("rst_mem_rready", mem_rready, 1);
        rst = 1'b0;
        @(negedge clk);

        // single burst from requester 3
        rq_pend[3] = 1; rq_addr[3] = 26'h0012340; rq_len[3] = 8'd3;
        p_new = 0; p_arready = 100; p_rvalid = 100; p_rready = 100;
        repeat (12) step();
        check("single_busy_clear", dut.r_busy, 0);
        check("single_out_cnt", dut.r_out_cnt, 0);
        check("single_beats_left", exp_beat_q.size(), 0);

        // outstanding limit: many requests, memory never answers
        p_new = 60; p_arready = 100; p_rvalid = 0; p_rready = 100;
        repeat (25) step();
        check("limit_out_cnt", dut.r_out_cnt, MAXO);
        drain();

        // mixed random traffic with backpressure windows
        for (int ph = 0; ph < 30; ph++) begin
            p_new     = $urandom_range(70, 10);
            p_arready = (ph % 5 == 0) ? 0 : $urandom_range(100, 0);
            p_rvalid  = $urandom_range(100, 20);
            p_rready  = $urandom_range(100, 30);
            repeat (100) step();
        end
        drain();
        check("drain_ar_empty", exp_ar_q.size(), 0);

        // unowned beat: dropped and flagged
        mem_rvalid = 1'b1; mem_rid = 3'd6; mem_rlast = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        req_rready = '0;
        #1;
        check("err_mem_rready", mem_rready, 1);
        check("err_req_rvalid", req_rvalid, 0);
        @(negedge clk);
        mem_rvalid = 1'b0;
        #1;
        check("err_set", err, 1);
        repeat (3) begin
            @(negedge clk);
            #1;
            check("err_sticky", err, 1);
        end
        @(negedge clk);

        // reset with a burst in flight
        rq_pend[2] = 1; rq_addr[2] = 26'h0000400; rq_len[2] = 8'd7;
        p_new = 0; p_arready = 0; p_rvalid = 0;
        repeat (2) step();
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("rst2_err", err, 0);
        check("rst2_busy", dut.r_busy, 0);
        check("rst2_mem_arvalid", mem_arvalid, 0);
        check("rst2_out_cnt", dut.r_out_cnt, 0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);

        // traffic resumes normally after reset
        for (int ph = 0; ph < 5; ph++) begin
            p_new = 40; p_arready = 70; p_rvalid = 70; p_rready = 80;
            repeat (100) step();
        end
        drain();
        check("final_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_mem_read_arbiter
`default_nettype wire
